multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath; sits directly upstream of ALU_Control.
//  Decodes IR opcode and sequences fetch/decode/execute/mem/writeback over several cycles.
//  Drives all datapath enables/muxes and ALUOp[1:0] (00 add, 01 sub, 10 use funct).
//  Stalls on a memory ready handshake.
// PARAMETERS
//  ADDI_EN  1  1: addi (001000) supported via ADDI_EX/ADDI_WB; 0: addi treated as illegal
// PORTS
//  clk          in   1  clock, all state updates on rising edge
//  reset        in   1  synchronous, active-high
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  mem_ready    in   1  memory completes access this cycle
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if ALU zero (beq)
//  i_or_d       out  1  0: mem addr = PC, 1: mem addr = ALUOut
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  mem_to_reg   out  1  1: RF write data = MDR
//  ir_write     out  1  IR load
//  pc_source    out  2  00 ALU, 01 ALUOut, 10 jump target
//  alu_op       out  2  to ALU_Control
//  alu_src_a    out  1  0 PC, 1 rs
//  alu_src_b    out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  reg_write    out  1  RF write enable
//  reg_dst      out  1  0 rt, 1 rd
//  illegal_op   out  1  one-cycle pulse on unsupported opcode
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  - Reset: state<=FETCH; while reset=1 every output is 0 (state_dbg=0). First fetch begins the cycle after reset deasserts.
//  - Outputs Moore-decoded from state, except pc_write/ir_write in FETCH gated by mem_ready.
//  - States (enc) / outputs / next:
//    FETCH(0): mem_read, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
//      stay until mem_ready=1 -> DECODE
//    DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. opcode: lw/sw(100011/101011)->MEM_ADDR,
//      R(000000)->EXECUTE, beq(000100)->BRANCH, j(000010)->JUMP, addi(001000,ADDI_EN)->ADDI_EX,
//      else illegal_op=1 -> FETCH
//    MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEM_READ, sw->MEM_WRITE
//    MEM_READ(3): mem_read, i_or_d=1; stay until mem_ready -> MEM_WB
//    MEM_WB(4): reg_write, mem_to_reg=1, reg_dst=0 -> FETCH
//    MEM_WRITE(5): mem_write, i_or_d=1; stay until mem_ready -> FETCH
//    EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB
//    R_WB(7): reg_write, reg_dst=1, mem_to_reg=0 -> FETCH
//    BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01 -> FETCH
//    JUMP(9): pc_write, pc_source=10 -> FETCH
//    ADDI_EX(10): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB
//    ADDI_WB(11): reg_write, reg_dst=0, mem_to_reg=0 -> FETCH
//  - Encodings 12-15 unreachable; if entered -> FETCH next cycle, illegal_op=1.
//  - Opcode sampled combinationally in DECODE and MEM_ADDR only; opcode changes elsewhere ignored.
//  - mem_ready ignored outside FETCH/MEM_READ/MEM_WRITE; no timeout on stall.
//  - mem_read/mem_write held high for the full stall; never both high.
//  - Reset mid-instruction (any state, incl. stalled) -> FETCH next edge; no partial writes.
//  - Latency with mem_ready=1: R 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
// STRUCTURE
//  - Shared package mips_ctrl_pkg: opcode constants, ALUOp codes (ADD=00,SUB=01,FUNCT=10),
//    state enum localparams, alu_src_b / pc_source encodings (also used by datapath muxes).
//  - Single module: state register + next-state logic + output decode; no sub-module.
// TESTING
//  1 reset: hold reset 3 cycles, mem_ready=1 -> all outputs 0; then FETCH, mem_read=1, ir_write=1.
//  2 R-type opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in EXECUTE; reg_write&reg_dst in R_WB.
//  3 lw opcode=100011, mem_ready low 2 cycles in MEM_READ -> state 3 held 3 cycles, mem_read+i_or_d held; MEM_WB reg_write, mem_to_reg=1.
//  4 beq 000100 -> 0,1,8,0; alu_op=01, pc_write_cond=1, pc_source=01 in BRANCH; j 000010 -> pc_write=1, pc_source=10.
//  5 opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, next state FETCH; ADDI_EN=0 with 001000 same.
//  6 reset asserted in MEM_WRITE while mem_ready=0 -> mem_write drops same cycle, state 0 next edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUOp codes,
// FSM state encodings and the datapath mux selects driven by the main controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EX   = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
  } ctrl_t;

  // State entered after DECODE; S_FETCH doubles as "unsupported opcode".
  function automatic logic [3:0] decode_target(input logic [5:0] op, input logic addi_en);
    logic [3:0] nxt;
    nxt = S_FETCH;
    case (op)
      OP_LW, OP_SW: nxt = S_MEM_ADDR;
      OP_RTYPE:     nxt = S_EXECUTE;
      OP_BEQ:       nxt = S_BRANCH;
      OP_J:         nxt = S_JUMP;
      OP_ADDI:      nxt = addi_en ? S_ADDI_EX : S_FETCH;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and mux select.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter bit ADDI_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  // Memory handshake: mem_read/mem_write is a request held high for as long as
  // the FSM sits in FETCH, MEM_READ or MEM_WRITE; the access completes on the
  // first rising edge where mem_ready=1. mem_ready is ignored in all other states.

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE:    state_d = decode_target(opcode, ADDI_EN);
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Moore decode; the only input dependencies are the FETCH load strobes and the
  // DECODE illegal-opcode pulse.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = ALUB_IMM_SH2;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = (decode_target(opcode, ADDI_EN) == S_FETCH);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: ctrl.illegal_op = 1'b1;
    endcase
  end

  // Reset squashes every output in the same cycle so a stalled access is dropped.
  assign ctrl_out = reset ? '0 : ctrl;

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign i_or_d        = ctrl_out.i_or_d;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign ir_write      = ctrl_out.ir_write;
  assign pc_source     = ctrl_out.pc_source;
  assign alu_op        = ctrl_out.alu_op;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign reg_write     = ctrl_out.reg_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign illegal_op    = ctrl_out.illegal_op;
  assign state_dbg     = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: instruction-level reference model builds a
// per-cycle stimulus/expectation trace, checked against ADDI_EN=1 and ADDI_EN=0 instances.
module tb_multicycle_main_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Clock / reset / shared inputs
  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [5:0] opcode;

  always #5 clk = ~clk;

  logic       m_pcw, m_pcwc, m_iord, m_mrd, m_mwr, m_m2r, m_irw, m_asa, m_rw, m_rd, m_ill;
  logic [1:0] m_pcs, m_aop, m_asb;
  logic [3:0] m_st;
  logic       n_pcw, n_pcwc, n_iord, n_mrd, n_mwr, n_m2r, n_irw, n_asa, n_rw, n_rd, n_ill;
  logic [1:0] n_pcs, n_aop, n_asb;
  logic [3:0] n_st;

  multicycle_main_control #(.ADDI_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(m_pcw), .pc_write_cond(m_pcwc), .i_or_d(m_iord), .mem_read(m_mrd),
    .mem_write(m_mwr), .mem_to_reg(m_m2r), .ir_write(m_irw), .pc_source(m_pcs),
    .alu_op(m_aop), .alu_src_a(m_asa), .alu_src_b(m_asb), .reg_write(m_rw),
    .reg_dst(m_rd), .illegal_op(m_ill), .state_dbg(m_st)
  );

  multicycle_main_control #(.ADDI_EN(1'b0)) dut_na (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(n_pcw), .pc_write_cond(n_pcwc), .i_or_d(n_iord), .mem_read(n_mrd),
    .mem_write(n_mwr), .mem_to_reg(n_m2r), .ir_write(n_irw), .pc_source(n_pcs),
    .alu_op(n_aop), .alu_src_a(n_asa), .alu_src_b(n_asb), .reg_write(n_rw),
    .reg_dst(n_rd), .illegal_op(n_ill), .state_dbg(n_st)
  );

  // {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
  //  pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, illegal_op}
  logic [20:0] obs_m, obs_n;
  assign obs_m = {m_st, m_pcw, m_pcwc, m_iord, m_mrd, m_mwr, m_m2r, m_irw,
                  m_pcs, m_aop, m_asa, m_asb, m_rw, m_rd, m_ill};
  assign obs_n = {n_st, n_pcw, n_pcwc, n_iord, n_mrd, n_mwr, n_m2r, n_irw,
                  n_pcs, n_aop, n_asa, n_asb, n_rw, n_rd, n_ill};

  // Scoreboard
  logic [20:0] exp_q[$];
  logic        stim_mr[$];
  logic [5:0]  stim_op[$];
  int          n_pass = 0;
  int          n_total = 0;
  bit          check_main = 1'b1;
  bit          check_na = 1'b1;
  string       cur_test = "none";

  function automatic logic [20:0] pack(input logic [3:0] st, input logic pcw, input logic pcwc,
                                       input logic iord, input logic mrd, input logic mwr,
                                       input logic m2r, input logic irw, input logic [1:0] pcs,
                                       input logic [1:0] aop, input logic asa, input logic [1:0] asb,
                                       input logic rw, input logic rd, input logic ill);
    return {st, pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, ill};
  endfunction

  // Output table of the controller, one row per named state (0 FETCH .. 11 ADDI_WB).
  function automatic logic [20:0] exp_vec(input int st, input logic mr, input logic ill);
    case (st)
      0:  return pack(4'd0,  mr,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mr,   2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
      1:  return pack(4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, ill);
      2:  return pack(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      3:  return pack(4'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      4:  return pack(4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      5:  return pack(4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      6:  return pack(4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      7:  return pack(4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
      8:  return pack(4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      9:  return pack(4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      10: return pack(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
      default: return pack(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    endcase
  endfunction

  // 0 illegal, 1 R, 2 lw, 3 sw, 4 beq, 5 j, 6 addi
  function automatic int classify(input logic [5:0] op, input bit addi_en);
    case (op)
      OP_R:    return 1;
      OP_LW:   return 2;
      OP_SW:   return 3;
      OP_BEQ:  return 4;
      OP_J:    return 5;
      OP_ADDI: return addi_en ? 6 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic push(input int st, input logic mr, input logic [5:0] op, input logic ill);
    stim_mr.push_back(mr);
    stim_op.push_back(op);
    exp_q.push_back(exp_vec(st, mr, ill));
  endtask

  function automatic logic [5:0] junk_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference model: one instruction expanded into its cycle-by-cycle trace.
  task automatic add_instr(input logic [5:0] op, input int fwait, input int mwait, input bit addi_en);
    int kind;
    kind = classify(op, addi_en);
    for (int i = 0; i < fwait; i++) push(0, 1'b0, junk_op(), 1'b0);
    push(0, 1'b1, junk_op(), 1'b0);
    push(1, rnd_bit(), op, kind == 0);
    case (kind)
      1: begin push(6, rnd_bit(), junk_op(), 1'b0); push(7, rnd_bit(), junk_op(), 1'b0); end
      2: begin
        push(2, rnd_bit(), op, 1'b0);
        for (int i = 0; i < mwait; i++) push(3, 1'b0, junk_op(), 1'b0);
        push(3, 1'b1, junk_op(), 1'b0);
        push(4, rnd_bit(), junk_op(), 1'b0);
      end
      3: begin
        push(2, rnd_bit(), op, 1'b0);
        for (int i = 0; i < mwait; i++) push(5, 1'b0, junk_op(), 1'b0);
        push(5, 1'b1, junk_op(), 1'b0);
      end
      4: push(8, rnd_bit(), junk_op(), 1'b0);
      5: push(9, rnd_bit(), junk_op(), 1'b0);
      6: begin push(10, rnd_bit(), junk_op(), 1'b0); push(11, rnd_bit(), junk_op(), 1'b0); end
      default: ;
    endcase
  endtask

  // Driver: replays n queued cycles (n<0: all), comparing at the falling edge.
  task automatic run_cycles(input int n);
    int k;
    logic [20:0] exp;
    k = 0;
    while (stim_mr.size() > 0 && (n < 0 || k < n)) begin
      mem_ready = stim_mr.pop_front();
      opcode    = stim_op.pop_front();
      exp       = exp_q.pop_front();
      @(negedge clk);
      if (check_main) begin
        n_total++;
        if (obs_m !== exp) $display("FAIL %s main cyc%0d: got %h need %h", cur_test, k, obs_m, exp);
        else n_pass++;
      end
      if (check_na) begin
        n_total++;
        if (obs_n !== exp) $display("FAIL %s noaddi cyc%0d: got %h need %h", cur_test, k, obs_n, exp);
        else n_pass++;
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic flush();
    exp_q.delete();
    stim_mr.delete();
    stim_op.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_R;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total += 2;
      if (obs_m !== 21'd0) $display("FAIL reset_zero main: got %h need 0", obs_m); else n_pass++;
      if (obs_n !== 21'd0) $display("FAIL reset_zero noaddi: got %h need 0", obs_n); else n_pass++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    add_instr(OP_R, 0, 0, 1'b1);
    run_cycles(-1);
  endtask

  task automatic test_rtype();
    cur_test = "rtype";
    apply_reset();
    add_instr(OP_R, 0, 0, 1'b1);
    add_instr(OP_R, 2, 0, 1'b1);
    run_cycles(-1);
  endtask

  task automatic test_lw_stall();
    cur_test = "lw_stall";
    apply_reset();
    add_instr(OP_LW, 0, 2, 1'b1);
    add_instr(OP_SW, 1, 0, 1'b1);
    add_instr(OP_SW, 0, 3, 1'b1);
    run_cycles(-1);
  endtask

  task automatic test_branch_jump();
    cur_test = "branch_jump";
    apply_reset();
    add_instr(OP_BEQ, 0, 0, 1'b1);
    add_instr(OP_J, 0, 0, 1'b1);
    add_instr(OP_BEQ, 1, 0, 1'b1);
    run_cycles(-1);
  endtask

  task automatic test_illegal();
    cur_test = "illegal";
    apply_reset();
    add_instr(OP_BAD, 0, 0, 1'b1);
    add_instr(OP_R, 0, 0, 1'b1);
    run_cycles(-1);
  endtask

  task automatic test_addi();
    cur_test = "addi_en1";
    apply_reset();
    check_na = 1'b0;
    add_instr(OP_ADDI, 0, 0, 1'b1);
    run_cycles(-1);
    cur_test = "addi_en0";
    apply_reset();
    check_main = 1'b0;
    check_na = 1'b1;
    add_instr(OP_ADDI, 0, 0, 1'b0);
    add_instr(OP_J, 0, 0, 1'b0);
    run_cycles(-1);
    check_main = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    cur_test = "reset_mid_write";
    apply_reset();
    add_instr(OP_SW, 0, 5, 1'b1);
    run_cycles(4);
    flush();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_total += 2;
    if (obs_m !== 21'd0) $display("FAIL reset_mid_write drop main: got %h need 0", obs_m); else n_pass++;
    if (obs_n !== 21'd0) $display("FAIL reset_mid_write drop noaddi: got %h need 0", obs_n); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_total += 2;
    if (obs_m !== exp_vec(0, 1'b0, 1'b0)) $display("FAIL reset_mid_write fetch main: got %h need %h", obs_m, exp_vec(0, 1'b0, 1'b0)); else n_pass++;
    if (obs_n !== exp_vec(0, 1'b0, 1'b0)) $display("FAIL reset_mid_write fetch noaddi: got %h need %h", obs_n, exp_vec(0, 1'b0, 1'b0)); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    logic [5:0] op;
    cur_test = "random";
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BAD};
    apply_reset();
    check_na = 1'b0;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == OP_BAD) op = junk_op();
      add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end
    run_cycles(-1);
    check_na = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch_jump();
    test_illegal();
    test_addi();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
